// File: rtl/input_conditioner.sv
// Synchronises and debounces 4 buttons and 7 switches, with optional per-button auto-repeat.
// Level and pulse outputs are registered; acceptance lands DEBOUNCE_CYCLES+2 edges after a steady input.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] buttons,
   input  logic [6:0] switches,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic [6:0] sw_level,
   output logic [6:0] sw_change
);

   localparam int NCH = 11;
   localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);
   localparam logic [25:0] DLY_MAX = 26'(REPEAT_DELAY - 1);
   localparam logic [25:0] PER_MAX = 26'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   logic [NCH-1:0] raw;
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;
   logic [NCH-1:0] level;
   logic [NCH-1:0] accept;
   logic [19:0]    stable_cnt [NCH];
   logic [3:0]     rise;
   logic [3:0]     fall;
   state_t         state [4];
   logic [25:0]    hold [4];

   assign raw       = {switches, buttons};
   assign btn_level = level[3:0];
   assign sw_level  = level[10:4];

   // A channel is accepted on the edge its counter would reach DEBOUNCE_CYCLES while still disagreeing.
   always_comb begin
      accept = '0;
      for (int i = 0; i < NCH; i++) begin
         accept[i] = (sync2[i] != level[i]) && (stable_cnt[i] == CNT_MAX);
      end
   end

   assign rise = accept[3:0] & ~level[3:0];
   assign fall = accept[3:0] & level[3:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         level     <= '0;
         sw_change <= '0;
         for (int i = 0; i < NCH; i++) begin
            stable_cnt[i] <= '0;
         end
      end else begin
         sync1     <= raw;
         sync2     <= sync1;
         sw_change <= accept[10:4];
         for (int i = 0; i < NCH; i++) begin
            if (accept[i]) begin
               level[i]      <= ~level[i];
               stable_cnt[i] <= '0;
            end else if (sync2[i] != level[i]) begin
               stable_cnt[i] <= stable_cnt[i] + 20'd1;
            end else begin
               stable_cnt[i] <= '0;
            end
         end
      end
   end

   // Release always wins over a repeat that would fire on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         btn_press <= '0;
         for (int i = 0; i < 4; i++) begin
            state[i] <= IDLE;
            hold[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            btn_press[i] <= 1'b0;
            case (state[i])
               IDLE: begin
                  hold[i] <= '0;
                  if (rise[i]) begin
                     btn_press[i] <= 1'b1;
                     if (REPEAT_EN != 0) begin
                        state[i] <= DELAY;
                     end
                  end
               end
               DELAY: begin
                  if (fall[i]) begin
                     state[i] <= IDLE;
                     hold[i]  <= '0;
                  end else if (hold[i] == DLY_MAX) begin
                     btn_press[i] <= 1'b1;
                     hold[i]      <= '0;
                     state[i]     <= REPEAT;
                  end else begin
                     hold[i] <= hold[i] + 26'd1;
                  end
               end
               REPEAT: begin
                  if (fall[i]) begin
                     state[i] <= IDLE;
                     hold[i]  <= '0;
                  end else if (hold[i] == PER_MAX) begin
                     btn_press[i] <= 1'b1;
                     hold[i]      <= '0;
                  end else begin
                     hold[i] <= hold[i] + 26'd1;
                  end
               end
               default: begin
                  state[i] <= IDLE;
                  hold[i]  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: one instance without auto-repeat, one with, sharing the same raw inputs.
module tb_input_conditioner;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] buttons;
   logic [6:0] switches;
   logic [3:0] n_btn_level, n_btn_press, r_btn_level, r_btn_press;
   logic [6:0] n_sw_level, n_sw_change, r_sw_level, r_sw_change;

   int checks = 0;
   int errors = 0;
   int cnt;
   logic exp_p;

   always #5 clock = ~clock;

   input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) u_norep (
      .clock(clock), .reset(reset), .buttons(buttons), .switches(switches),
      .btn_level(n_btn_level), .btn_press(n_btn_press), .sw_level(n_sw_level), .sw_change(n_sw_change));

   input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) u_rep (
      .clock(clock), .reset(reset), .buttons(buttons), .switches(switches),
      .btn_level(r_btn_level), .btn_press(r_btn_press), .sw_level(r_sw_level), .sw_change(r_sw_change));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_n"}, {10'd0, n_btn_level, n_btn_press, n_sw_level, n_sw_change}, 32'd0);
      chk({tag, "_r"}, {10'd0, r_btn_level, r_btn_press, r_sw_level, r_sw_change}, 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      buttons  = 4'h0;
      switches = 7'h00;
      tick(2);
      chk_all_zero("reset_state");
      reset = 1'b0;
      tick(8);
      chk_all_zero("idle_after_reset");

      // Clean press on buttons[0]
      buttons = 4'b0001;
      tick(5);
      chk("press_before_accept", {28'd0, n_btn_level}, 32'h0);
      tick(1);
      chk("press_level_edge6", {28'd0, n_btn_level}, 32'h1);
      chk("press_pulse_edge6_n", {28'd0, n_btn_press}, 32'h1);
      chk("press_pulse_edge6_r", {28'd0, r_btn_press}, 32'h1);
      tick(1);
      chk("press_pulse_one_cycle", {28'd0, n_btn_press}, 32'h0);
      cnt = 0;
      for (int k = 0; k < 13; k++) begin
         tick(1);
         if (n_btn_press[0]) cnt++;
      end
      chk("press_no_extra_pulse", cnt, 0);
      buttons = 4'b0000;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (n_btn_press[0]) cnt++;
      end
      chk("release_no_pulse", cnt, 0);
      chk("release_level_n", {28'd0, n_btn_level}, 32'h0);
      chk("release_level_r", {28'd0, r_btn_level}, 32'h0);
      tick(4);

      // Bouncing switches[3]
      switches = 7'b0001000; tick(1);
      switches = 7'b0000000; tick(1);
      switches = 7'b0001000; tick(1);
      switches = 7'b0000000; tick(1);
      switches = 7'b0001000;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         if (n_sw_change[3] || n_sw_level[3]) cnt++;
      end
      chk("bounce_no_early_change", cnt, 0);
      tick(1);
      chk("bounce_change_pulse", {25'd0, n_sw_change}, 32'h08);
      chk("bounce_level", {25'd0, n_sw_level}, 32'h08);
      tick(1);
      chk("bounce_pulse_one_cycle", {25'd0, n_sw_change}, 32'h00);
      switches = 7'b0000000;
      tick(5);
      chk("sw_fall_before", {25'd0, n_sw_change}, 32'h00);
      tick(1);
      chk("sw_fall_change_pulse", {25'd0, n_sw_change}, 32'h08);
      chk("sw_fall_level", {25'd0, n_sw_level}, 32'h00);
      tick(4);

      // Auto-repeat on buttons[2]
      buttons = 4'b0100;
      tick(6);
      chk("rep_press_rel0_r", {28'd0, r_btn_press}, 32'h4);
      chk("rep_press_rel0_n", {28'd0, n_btn_press}, 32'h4);
      for (int k = 1; k <= 30; k++) begin
         if (k == 25) buttons = 4'b0000;
         tick(1);
         exp_p = (k == 10) || (k == 15) || (k == 20) || (k == 25);
         chk($sformatf("rep_pulse_rel%0d", k), {30'd0, n_btn_press[2], r_btn_press[2]}, {30'd0, 1'b0, exp_p});
      end
      chk("rep_release_level", {28'd0, r_btn_level}, 32'h0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         if (r_btn_press != 4'h0) cnt++;
      end
      chk("rep_idle_after_release", cnt, 0);

      // All eleven channels at once
      buttons  = 4'hF;
      switches = 7'h7F;
      tick(5);
      chk_all_zero("simul_before");
      tick(1);
      chk("simul_r", {10'd0, r_btn_level, r_btn_press, r_sw_level, r_sw_change}, {10'd0, 4'hF, 4'hF, 7'h7F, 7'h7F});
      chk("simul_n", {10'd0, n_btn_level, n_btn_press, n_sw_level, n_sw_change}, {10'd0, 4'hF, 4'hF, 7'h7F, 7'h7F});
      tick(1);
      chk("simul_pulses_clear", {18'd0, r_btn_press, n_btn_press, r_sw_change}, 32'h0);
      buttons  = 4'h0;
      switches = 7'h00;
      tick(6);
      chk("simul_release", {10'd0, r_btn_level, r_btn_press, r_sw_level, r_sw_change}, {10'd0, 4'h0, 4'h0, 7'h00, 7'h7F});
      tick(4);

      // Reset in the middle of the repeat delay, input held through release
      buttons = 4'b0010;
      tick(6);
      chk("rst_press", {28'd0, r_btn_press}, 32'h2);
      tick(7);
      reset = 1'b1;
      tick(1);
      chk_all_zero("rst_mid_delay");
      reset = 1'b0;
      tick(5);
      chk("rst_reaccept_before", {24'd0, r_btn_level, r_btn_press}, 32'h0);
      tick(1);
      chk("rst_reaccept", {24'd0, r_btn_level, r_btn_press}, 32'h22);
      chk("rst_reaccept_n", {24'd0, n_btn_level, n_btn_press}, 32'h22);
      tick(1);
      chk("rst_reaccept_pulse_clear", {28'd0, r_btn_press}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
